// File: rtl/updi_rx_engine.sv
// ============================================================================
// Module   : updi_rx_engine
// Purpose  : UPDI receive engine between the UART RX FIFO and the programmer
//            data FIFO. ACK mode checks one received byte against ACK_VALUE;
//            burst mode forwards n_bytes_i bytes to the output FIFO. Provides
//            abort, a done pulse, a bytes-remaining status and an optional
//            empty-FIFO wait limit.
// Options  : `define UPDI_RX_TIMEOUT_EN to enable the RX wait-limit timer.
//            Without it, timeout_o is tied low and the engine waits forever.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module updi_rx_engine #(
   parameter int                 DATA_W    = 8,
   parameter int                 BITS_N    = 6,
   parameter logic [DATA_W-1:0]  ACK_VALUE = 8'h40,
   parameter int                 TIMEOUT_W = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  start_i,
   input  logic [BITS_N-1:0]     n_bytes_i,
   input  logic                  wait_ack_i,
   input  logic                  abort_i,
   input  logic [TIMEOUT_W-1:0]  timeout_cycles_i,
   output logic                  ready_o,
   output logic                  done_o,
   output logic                  ack_received_o,
   output logic                  ack_error_o,
   output logic                  timeout_o,
   output logic [BITS_N-1:0]     bytes_left_o,
   input  logic [DATA_W-1:0]     in_fifo_data_i,
   input  logic                  in_fifo_empty_i,
   output logic                  in_fifo_rd_en_o,
   output logic [DATA_W-1:0]     out_fifo_data_o,
   input  logic                  out_fifo_full_i,
   output logic                  out_fifo_wr_en_o
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RD      = 3'd1,
      S_WR      = 3'd2,
      S_ACK_RD  = 3'd3,
      S_ACK_CHK = 3'd4,
      S_DONE    = 3'd5
   } state_t;

   state_t              state_q, state_d;
   logic [BITS_N-1:0]   cnt_q, cnt_d;
   logic                tmo_hit;

`ifdef UPDI_RX_TIMEOUT_EN
   logic [TIMEOUT_W-1:0] idle_q, idle_d;

   // Wait limit reached: idle counter has counted timeout_cycles-1 empty cycles.
   assign tmo_hit = (timeout_cycles_i != '0) &&
                    (idle_q >= (timeout_cycles_i - TIMEOUT_W'(1)));

   // Count empty-FIFO cycles while waiting to read; any read or other state clears it.
   always_comb begin
      idle_d = '0;
      if ((state_q == S_RD || state_q == S_ACK_RD) && in_fifo_empty_i && !tmo_hit) begin
         idle_d = idle_q + TIMEOUT_W'(1);
      end
   end

   // Idle counter register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         idle_q <= '0;
      end else begin
         idle_q <= idle_d;
      end
   end
`else
   logic unused_timeout_cycles;
   assign unused_timeout_cycles = ^timeout_cycles_i;
   assign tmo_hit = 1'b0;
`endif

   // Data passes straight through; the write strobe qualifies it.
   assign out_fifo_data_o = in_fifo_data_i;

   // Remaining count is only meaningful while a burst is moving.
   assign bytes_left_o = (state_q == S_RD || state_q == S_WR) ? cnt_q : '0;

   // Next-state, counter and strobe decode; abort overrides everything last.
   always_comb begin
      state_d          = state_q;
      cnt_d            = cnt_q;
      ready_o          = 1'b0;
      done_o           = 1'b0;
      ack_received_o   = 1'b0;
      ack_error_o      = 1'b0;
      timeout_o        = 1'b0;
      in_fifo_rd_en_o  = 1'b0;
      out_fifo_wr_en_o = 1'b0;

      case (state_q)
         S_IDLE: begin
            ready_o = 1'b1;
            cnt_d   = '0;
            if (start_i) begin
               if (n_bytes_i != '0) begin
                  cnt_d   = n_bytes_i;
                  state_d = S_RD;
               end else begin
                  state_d = S_DONE;
               end
            end else if (wait_ack_i) begin
               state_d = S_ACK_RD;
            end
         end
         S_RD: begin
            in_fifo_rd_en_o = !in_fifo_empty_i;
            if (!in_fifo_empty_i) begin
               state_d = S_WR;
            end else if (tmo_hit) begin
               timeout_o = 1'b1;
               cnt_d     = '0;
               state_d   = S_IDLE;
            end
         end
         S_WR: begin
            // A full output FIFO holds the byte here; the RX FIFO is not re-read.
            out_fifo_wr_en_o = !out_fifo_full_i;
            if (!out_fifo_full_i) begin
               if (cnt_q == BITS_N'(1)) begin
                  cnt_d   = '0;
                  state_d = S_DONE;
               end else begin
                  cnt_d   = cnt_q - BITS_N'(1);
                  state_d = S_RD;
               end
            end
         end
         S_ACK_RD: begin
            in_fifo_rd_en_o = !in_fifo_empty_i;
            if (!in_fifo_empty_i) begin
               state_d = S_ACK_CHK;
            end else if (tmo_hit) begin
               timeout_o = 1'b1;
               state_d   = S_IDLE;
            end
         end
         S_ACK_CHK: begin
            if (in_fifo_data_i == ACK_VALUE) begin
               ack_received_o = 1'b1;
            end else begin
               ack_error_o = 1'b1;
            end
            state_d = S_IDLE;
         end
         S_DONE: begin
            done_o  = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            cnt_d   = '0;
            state_d = S_IDLE;
         end
      endcase

      if (abort_i && state_q != S_IDLE) begin
         state_d          = S_IDLE;
         cnt_d            = '0;
         done_o           = 1'b0;
         ack_received_o   = 1'b0;
         ack_error_o      = 1'b0;
         timeout_o        = 1'b0;
         in_fifo_rd_en_o  = 1'b0;
         out_fifo_wr_en_o = 1'b0;
      end
   end

   // State and burst counter registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_updi_rx_engine.sv
// ============================================================================
// Module   : tb_updi_rx_engine
// Purpose  : Self-checking bench for updi_rx_engine with FIFO models and a
//            transaction-level expectation of bytes, pulses and strobes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_updi_rx_engine;

   localparam int BITS_N = 6;
   localparam int TW     = 16;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start_i, wait_ack_i, abort_i;
   logic [BITS_N-1:0] n_bytes_i;
   logic [TW-1:0]     timeout_cycles_i;
   logic              ready_o, done_o, ack_received_o, ack_error_o, timeout_o;
   logic [BITS_N-1:0] bytes_left_o;
   logic [7:0]        in_fifo_data = 8'h00;
   logic              in_fifo_empty, in_fifo_rd_en_o;
   logic [7:0]        out_fifo_data_o;
   logic              out_fifo_full_i, out_fifo_wr_en_o;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   updi_rx_engine #(.DATA_W(8), .BITS_N(BITS_N), .ACK_VALUE(8'h40), .TIMEOUT_W(TW)) dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start_i), .n_bytes_i(n_bytes_i),
      .wait_ack_i(wait_ack_i), .abort_i(abort_i), .timeout_cycles_i(timeout_cycles_i),
      .ready_o(ready_o), .done_o(done_o), .ack_received_o(ack_received_o),
      .ack_error_o(ack_error_o), .timeout_o(timeout_o), .bytes_left_o(bytes_left_o),
      .in_fifo_data_i(in_fifo_data), .in_fifo_empty_i(in_fifo_empty),
      .in_fifo_rd_en_o(in_fifo_rd_en_o), .out_fifo_data_o(out_fifo_data_o),
      .out_fifo_full_i(out_fifo_full_i), .out_fifo_wr_en_o(out_fifo_wr_en_o)
   );

   // RX FIFO model: bench writes rx_mem/rx_wp, read side pops on rd_en.
   logic [7:0] rx_mem [0:1023];
   int         rx_wp = 0;
   int         rx_rp;
   assign in_fifo_empty = (rx_wp == rx_rp);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_rp <= rx_wp;
      end else if (in_fifo_rd_en_o && rx_rp != rx_wp) begin
         in_fifo_data <= rx_mem[rx_rp % 1024];
         rx_rp        <= rx_rp + 1;
      end
   end

   // Monitor: counts strobes/pulses and records every byte written out.
   logic [7:0]        out_mem [0:4095];
   logic [BITS_N-1:0] bl_mem  [0:4095];
   int out_n = 0, n_rd = 0, n_wr = 0, n_done = 0, n_ackr = 0, n_acke = 0, n_tmo = 0;

   always @(negedge clk) begin
      if (in_fifo_rd_en_o) n_rd++;
      if (out_fifo_wr_en_o) begin
         out_mem[out_n % 4096] = out_fifo_data_o;
         bl_mem[out_n % 4096]  = bytes_left_o;
         out_n++;
         n_wr++;
      end
      if (done_o)         n_done++;
      if (ack_received_o) n_ackr++;
      if (ack_error_o)    n_acke++;
      if (timeout_o)      n_tmo++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] b);
      rx_mem[rx_wp % 1024] = b;
      rx_wp++;
   endtask

   task automatic flush_reset();
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic wait_idle(input int bound, input bit rand_full, input string tag);
      bit seen = 1'b0;
      for (int c = 0; c < bound; c++) begin
         @(negedge clk);
         if (ready_o) begin
            seen = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
         if (rand_full) out_fifo_full_i = ($urandom_range(0, 2) == 0);
      end
      out_fifo_full_i = 1'b0;
      total++;
      if (!seen) begin
         bad++;
         $display("FAIL %s idle_wait: ready=%b required 1 within %0d cycles", tag, ready_o, bound);
      end
      @(posedge clk);
      #1;
   endtask

   // Burst transaction: expected output is exactly the pushed bytes, one done,
   // one RX read per byte, bytes_left counting n..1 at the writes.
   task automatic run_burst(input logic [7:0] bytes[$], input bit rand_full,
                            input bit with_ack, input string tag);
      int n      = bytes.size();
      int b_rd   = n_rd;
      int b_wr   = n_wr;
      int b_done = n_done;
      int b_ack  = n_ackr + n_acke;
      int b_out  = out_n;
      foreach (bytes[i]) push(bytes[i]);
      start_i    = 1'b1;
      wait_ack_i = with_ack;
      n_bytes_i  = BITS_N'(n);
      tick();
      start_i    = 1'b0;
      wait_ack_i = 1'b0;
      wait_idle(n * 12 + 40, rand_full, tag);
      total++;
      if (n_wr - b_wr != n || n_rd - b_rd != n || n_done - b_done != 1) begin
         bad++;
         $display("FAIL %s counts: wr=%0d rd=%0d done=%0d required wr=%0d rd=%0d done=1",
                  tag, n_wr - b_wr, n_rd - b_rd, n_done - b_done, n, n);
      end
      total++;
      if (n_ackr + n_acke != b_ack) begin
         bad++;
         $display("FAIL %s ack_pulses: got %0d required 0", tag, n_ackr + n_acke - b_ack);
      end
      for (int i = 0; i < n; i++) begin
         total++;
         if (out_mem[(b_out + i) % 4096] !== bytes[i] ||
             bl_mem[(b_out + i) % 4096] !== BITS_N'(n - i)) begin
            bad++;
            $display("FAIL %s byte%0d: data=%h left=%0d required data=%h left=%0d", tag, i,
                     out_mem[(b_out + i) % 4096], bl_mem[(b_out + i) % 4096], bytes[i], n - i);
         end
      end
   endtask

   task automatic run_ack(input logic [7:0] b, input string tag);
      int b_r = n_ackr;
      int b_e = n_acke;
      int b_w = n_wr;
      push(b);
      wait_ack_i = 1'b1;
      tick();
      wait_ack_i = 1'b0;
      wait_idle(20, 1'b0, tag);
      total++;
      if (n_ackr - b_r != int'(b == 8'h40) || n_acke - b_e != int'(b != 8'h40) || n_wr != b_w) begin
         bad++;
         $display("FAIL %s ack(%h): received=%0d error=%0d wr=%0d required received=%0d error=%0d wr=0",
                  tag, b, n_ackr - b_r, n_acke - b_e, n_wr - b_w, int'(b == 8'h40), int'(b != 8'h40));
      end
   endtask

   task automatic test_reset();
      int b_wr;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++;
      if ({ready_o, done_o, ack_received_o, ack_error_o, timeout_o, in_fifo_rd_en_o,
           out_fifo_wr_en_o, bytes_left_o} !== {1'b1, 6'b0, 6'd0}) begin
         bad++;
         $display("FAIL reset_state: ready=%b strobes=%b%b%b%b%b%b left=%0d required ready=1 strobes=0 left=0",
                  ready_o, done_o, ack_received_o, ack_error_o, timeout_o, in_fifo_rd_en_o,
                  out_fifo_wr_en_o, bytes_left_o);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();
      // Reset in the middle of a 5-byte burst, right after the second write.
      for (int i = 0; i < 5; i++) push(8'(8'hA0 + i));
      b_wr = n_wr;
      start_i   = 1'b1;
      n_bytes_i = 6'd5;
      tick();
      start_i = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         #1;
         if (n_wr - b_wr >= 2) break;
      end
      total++;
      if (n_wr - b_wr != 2) begin
         bad++;
         $display("FAIL reset_mid_progress: writes=%0d required 2", n_wr - b_wr);
      end
      rst_n = 1'b0;
      #1;
      total++;
      if (ready_o !== 1'b1 || bytes_left_o !== '0 || in_fifo_rd_en_o !== 1'b0 ||
          out_fifo_wr_en_o !== 1'b0 || done_o !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid_burst: ready=%b left=%0d rd=%b wr=%b done=%b required 1,0,0,0,0",
                  ready_o, bytes_left_o, in_fifo_rd_en_o, out_fifo_wr_en_o, done_o);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_burst_fixed();
      logic [7:0] q[$] = '{8'h11, 8'h22, 8'h33};
      run_burst(q, 1'b0, 1'b0, "burst3");
      @(negedge clk);
      total++;
      if (ready_o !== 1'b1 || bytes_left_o !== '0) begin
         bad++;
         $display("FAIL burst3_idle: ready=%b left=%0d required 1 and 0", ready_o, bytes_left_o);
      end
      tick();
   endtask

   task automatic test_backpressure();
      int b_rd = n_rd;
      int b_wr = n_wr;
      int b_d  = n_done;
      int b_o  = out_n;
      bit early_wr = 1'b0;
      out_fifo_full_i = 1'b1;
      push(8'h5A);
      push(8'hC3);
      start_i   = 1'b1;
      n_bytes_i = 6'd2;
      tick();
      start_i = 1'b0;
      tick();
      repeat (4) begin
         @(negedge clk);
         if (out_fifo_wr_en_o) early_wr = 1'b1;
         tick();
      end
      total++;
      if (early_wr || n_rd - b_rd != 1 || n_wr != b_wr) begin
         bad++;
         $display("FAIL stall_hold: wr_seen=%b rd=%0d wr=%0d required 0,1,0", early_wr, n_rd - b_rd, n_wr - b_wr);
      end
      out_fifo_full_i = 1'b0;
      wait_idle(30, 1'b0, "stall");
      total++;
      if (n_rd - b_rd != 2 || n_wr - b_wr != 2 || n_done - b_d != 1 ||
          out_mem[b_o % 4096] !== 8'h5A || out_mem[(b_o + 1) % 4096] !== 8'hC3) begin
         bad++;
         $display("FAIL stall_result: rd=%0d wr=%0d done=%0d data=%h,%h required 2,2,1 5a,c3",
                  n_rd - b_rd, n_wr - b_wr, n_done - b_d, out_mem[b_o % 4096], out_mem[(b_o + 1) % 4096]);
      end
   endtask

   task automatic test_ack();
      run_ack(8'h40, "ack_match");
      run_ack(8'h41, "ack_miss");
      for (int i = 0; i < 6; i++) begin
         logic [7:0] v = ($urandom_range(0, 1) == 0) ? 8'h40 : 8'($urandom);
         run_ack(v, "ack_rand");
      end
   endtask

   task automatic test_zero_len();
      int b_rd = n_rd;
      int b_wr = n_wr;
      start_i   = 1'b1;
      n_bytes_i = '0;
      tick();
      start_i = 1'b0;
      @(negedge clk);
      total++;
      if (done_o !== 1'b1 || ready_o !== 1'b0) begin
         bad++;
         $display("FAIL zero_len_done: done=%b ready=%b required 1 and 0", done_o, ready_o);
      end
      tick();
      @(negedge clk);
      total++;
      if (ready_o !== 1'b1 || n_rd != b_rd || n_wr != b_wr) begin
         bad++;
         $display("FAIL zero_len_access: ready=%b rd=%0d wr=%0d required 1,0,0", ready_o, n_rd - b_rd, n_wr - b_wr);
      end
      tick();
   endtask

   task automatic test_priority();
      logic [7:0] q[$] = '{8'h40, 8'h99};
      run_burst(q, 1'b0, 1'b1, "start_and_ack");
   endtask

   task automatic test_abort();
      int b_wr = n_wr;
      int b_d  = n_done;
      logic [7:0] q[$];
      push(8'h01);
      push(8'h02);
      push(8'h03);
      start_i   = 1'b1;
      n_bytes_i = 6'd3;
      tick();
      start_i = 1'b0;
      tick();
      abort_i = 1'b1;
      @(negedge clk);
      total++;
      if (out_fifo_wr_en_o !== 1'b0 || in_fifo_rd_en_o !== 1'b0 || bytes_left_o !== 6'd3) begin
         bad++;
         $display("FAIL abort_in_wr: wr=%b rd=%b left=%0d required 0,0,3", out_fifo_wr_en_o, in_fifo_rd_en_o, bytes_left_o);
      end
      tick();
      abort_i = 1'b0;
      @(negedge clk);
      total++;
      if (ready_o !== 1'b1 || bytes_left_o !== '0 || n_wr != b_wr || n_done != b_d) begin
         bad++;
         $display("FAIL abort_idle: ready=%b left=%0d wr=%0d done=%0d required 1,0,0,0",
                  ready_o, bytes_left_o, n_wr - b_wr, n_done - b_d);
      end
      tick();
      flush_reset();
      // Abort while idle must not block a start in the same cycle.
      abort_i = 1'b1;
      q = '{8'h7E};
      push(q[0]);
      start_i   = 1'b1;
      n_bytes_i = 6'd1;
      b_wr = n_wr;
      b_d  = n_done;
      tick();
      start_i = 1'b0;
      abort_i = 1'b0;
      wait_idle(20, 1'b0, "abort_in_idle");
      total++;
      if (n_wr - b_wr != 1 || n_done - b_d != 1 || out_mem[(out_n - 1) % 4096] !== 8'h7E) begin
         bad++;
         $display("FAIL abort_in_idle: wr=%0d done=%0d data=%h required 1,1,7e",
                  n_wr - b_wr, n_done - b_d, out_mem[(out_n - 1) % 4096]);
      end
   endtask

   task automatic test_timeout();
      int k    = 0;
      int b_t  = n_tmo;
      int b_d  = n_done;
      timeout_cycles_i = 16'd10;
      start_i   = 1'b1;
      n_bytes_i = 6'd1;
      tick();
      start_i = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (timeout_o) begin
            k = c;
            break;
         end
         if (c != 40) tick();
      end
`ifdef UPDI_RX_TIMEOUT_EN
      total++;
      if (k != 10) begin
         bad++;
         $display("FAIL timeout_cycle: pulse on cycle %0d required 10", k);
      end
      tick();
      @(negedge clk);
      total++;
      if (ready_o !== 1'b1 || n_tmo - b_t != 1 || n_done != b_d) begin
         bad++;
         $display("FAIL timeout_idle: ready=%b tmo=%0d done=%0d required 1,1,0", ready_o, n_tmo - b_t, n_done - b_d);
      end
      tick();
`else
      total++;
      if (k != 0 || ready_o !== 1'b0 || bytes_left_o !== 6'd1) begin
         bad++;
         $display("FAIL no_timeout: pulse cycle=%0d ready=%b left=%0d required 0,0,1", k, ready_o, bytes_left_o);
      end
      tick();
      abort_i = 1'b1;
      tick();
      abort_i = 1'b0;
      @(negedge clk);
      total++;
      if (ready_o !== 1'b1 || n_tmo != b_t || n_done != b_d) begin
         bad++;
         $display("FAIL no_timeout_abort: ready=%b tmo=%0d done=%0d required 1,0,0", ready_o, n_tmo - b_t, n_done - b_d);
      end
      tick();
`endif
      timeout_cycles_i = '0;
   endtask

   task automatic test_random();
      for (int it = 0; it < 12; it++) begin
         logic [7:0] q[$];
         int n = $urandom_range(1, 40);
         for (int i = 0; i < n; i++) q.push_back(8'($urandom));
         run_burst(q, 1'b1, 1'b0, "rand_burst");
      end
   endtask

   task automatic test_back_to_back();
      for (int it = 0; it < 3; it++) begin
         logic [7:0] q[$];
         for (int i = 0; i < 4; i++) q.push_back(8'($urandom));
         run_burst(q, 1'b0, 1'b0, "b2b_burst");
         run_ack(8'h40, "b2b_ack");
      end
   endtask

   initial begin
      rst_n            = 1'b0;
      start_i          = 1'b0;
      wait_ack_i       = 1'b0;
      abort_i          = 1'b0;
      n_bytes_i        = '0;
      timeout_cycles_i = '0;
      out_fifo_full_i  = 1'b0;
      test_reset();
      test_burst_fixed();
      test_backpressure();
      test_ack();
      test_zero_len();
      test_priority();
      test_abort();
      test_timeout();
      test_random();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
